// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, ALUOp encoding and funct7 constants
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ALUOP_LDST   = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    // Base-encoding operation selected by funct3 (funct7 = F7_BASE)
    function automatic logic [3:0] funct3_code(input logic [2:0] funct3);
        logic [3:0] code;
        case (funct3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational instr/alu_op to ALU control code decode
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic [XLEN-1:0]   instr,
    input  logic [1:0]        alu_op,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal
);

    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [3:0] code;
    logic       bad;
    logic       unused_instr;

    assign funct7       = instr[31:25];
    assign funct3       = instr[14:12];
    // Register and immediate fields are irrelevant to the ALU control code
    assign unused_instr = ^instr;

    // Decode funct fields; an illegal combination falls back to ADD
    always_comb begin
        code = ALU_ADD;
        bad  = 1'b0;
        case (aluop_e'(alu_op))
            ALUOP_LDST:   code = ALU_ADD;
            ALUOP_BRANCH: code = ALU_SUB;
            ALUOP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    code = funct3_code(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    code = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    code = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            default: begin
                // Immediate forms: funct7 is immediate data except for shifts
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) begin
                        code = ALU_SLL;
                    end else begin
                        bad = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE) begin
                        code = ALU_SRL;
                    end else if (funct7 == F7_ALT) begin
                        code = ALU_SRA;
                    end else begin
                        bad = 1'b1;
                    end
                end else begin
                    code = funct3_code(funct3);
                end
            end
        endcase
        if (bad) begin
            code = ALU_ADD;
        end
    end

    assign alu_ctrl = CTRL_W'(code);
    assign illegal  = bad;

endmodule

// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered ALU-control decode stage with skid buffer and illegal-op counter
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   instr,
    input  logic [1:0]        alu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    input  logic              flush,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q,  out_ctrl_d;
    logic              out_ill_q,   out_ill_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic              skid_ill_q,   skid_ill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;
    logic out_free;

    alu_ctrl_decode #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .instr    (instr),
        .alu_op   (alu_op),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

    // in_ready depends only on the skid flop, never on out_ready
    assign in_ready = ~skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;
    assign out_free = out_fire | ~out_valid_q;

    // Next-state for output register and skid entry; flush overrides every transfer
    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_ill_d   = skid_ill_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Skid is older than anything arriving (in_ready is low anyway)
                out_valid_d  = 1'b1;
                out_ctrl_d   = skid_ctrl_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = dec_ctrl;
                out_ill_d   = dec_illegal;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = dec_ctrl;
            skid_ill_d   = dec_illegal;
        end
    end

    // Saturating count of accepted illegal ops; a flushed input is never counted
    always_comb begin
        cnt_d = cnt_q;
        if (in_fire && !flush && dec_illegal && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_ill_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_ill_q   <= skid_ill_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_ctrl    = out_ctrl_q;
    assign illegal     = out_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - scoreboard bench for alu_ctrl_stage
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [1:0]  alu_op;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic        illegal;
    logic        flush;
    logic [15:0] illegal_cnt;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_instr;
    logic [1:0]  s_alu_op;
    logic        s_out_valid;
    logic [3:0]  s_alu_ctrl;
    logic        s_illegal;
    logic [1:0]  s_illegal_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    logic [4:0]  sb[$];
    logic [15:0] exp_cnt;
    logic        hold_v;
    logic [3:0]  hold_ctrl;
    logic        hold_ill;

    always #5 clk = ~clk;

    alu_ctrl_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .illegal     (illegal),
        .flush       (flush),
        .illegal_cnt (illegal_cnt)
    );

    alu_ctrl_stage #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (s_in_valid),
        .in_ready    (s_in_ready),
        .instr       (s_instr),
        .alu_op      (s_alu_op),
        .out_valid   (s_out_valid),
        .out_ready   (1'b1),
        .alu_ctrl    (s_alu_ctrl),
        .illegal     (s_illegal),
        .flush       (1'b0),
        .illegal_cnt (s_illegal_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        logic [9:0]  mid;
        logic [11:0] low;
        mid = 10'($urandom);
        low = 12'($urandom);
        return {f7, mid, f3, low};
    endfunction

    // Reference decode: {illegal, code}
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [31:0] ins);
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] base;
        logic [3:0] c;
        logic       ill;
        f7  = ins[31:25];
        f3  = ins[14:12];
        ill = 1'b0;
        case (f3)
            3'd0: base = 4'd2;
            3'd1: base = 4'd4;
            3'd2: base = 4'd7;
            3'd3: base = 4'd8;
            3'd4: base = 4'd3;
            3'd5: base = 4'd5;
            3'd6: base = 4'd1;
            default: base = 4'd0;
        endcase
        c = base;
        if (op == 2'b00) c = 4'd2;
        else if (op == 2'b01) c = 4'd6;
        else if (op == 2'b10) begin
            if (f7 == 7'h00) c = base;
            else if (f7 == 7'h20 && f3 == 3'd0) c = 4'd6;
            else if (f7 == 7'h20 && f3 == 3'd5) c = 4'd9;
            else ill = 1'b1;
        end else begin
            if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
            else if (f3 == 3'd5) begin
                if (f7 == 7'h00) c = 4'd5;
                else if (f7 == 7'h20) c = 4'd9;
                else ill = 1'b1;
            end
        end
        if (ill) c = 4'd2;
        return {ill, c};
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst_n) begin
            sb.delete();
            exp_cnt = 16'd0;
            hold_v  = 1'b0;
        end else begin
            check_eq("illegal_cnt", illegal_cnt, exp_cnt);
            if (hold_v && !flush) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_ctrl", alu_ctrl, hold_ctrl);
                check_eq("hold_ill", illegal, hold_ill);
            end
            hold_v = 1'b0;
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_out", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("out_ctrl", alu_ctrl, e[3:0]);
                        check_eq("out_ill", illegal, e[4]);
                    end
                end else if (out_valid) begin
                    hold_v    = 1'b1;
                    hold_ctrl = alu_ctrl;
                    hold_ill  = illegal;
                end
                if (in_valid && in_ready) begin
                    e = ref_dec(alu_op, instr);
                    sb.push_back(e);
                    if (e[4] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] ins);
        logic acc;
        in_valid = 1'b1;
        alu_op   = op;
        instr    = ins;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0]  sw_f7[10];
        logic [2:0]  sw_f3[10];
        logic [15:0] saved_cnt;
        logic [1:0]  sat_exp[5];

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; alu_op = 2'b00;
        out_ready = 1'b0; flush = 1'b0;
        s_in_valid = 1'b0; s_instr = '0; s_alu_op = 2'b10;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_alu_ctrl", alu_ctrl, 0);
        check_eq("rst_cnt", illegal_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // R-type sweep at full throughput
        for (int i = 0; i < 8; i++) begin
            sw_f7[i] = 7'h00;
            sw_f3[i] = 3'(i);
        end
        sw_f7[8] = 7'h20; sw_f3[8] = 3'd0;
        sw_f7[9] = 7'h20; sw_f3[9] = 3'd5;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            alu_op   = 2'b10;
            instr    = mk(sw_f7[i], sw_f3[i]);
            @(negedge clk);
            check_eq("sweep_in_ready", in_ready, 1);
            check_eq("sweep_latency", out_valid, (i > 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("sweep_last", out_valid, 1);
        idle(2);

        // Load/store, branch and I-type cases
        send(2'b00, mk(7'h55, 3'd7));
        send(2'b01, mk(7'h00, 3'd3));
        send(2'b11, mk(7'h20, 3'd0));
        send(2'b11, mk(7'h20, 3'd5));
        send(2'b11, mk(7'h20, 3'd1));
        send(2'b11, mk(7'h00, 3'd1));
        send(2'b11, mk(7'h7f, 3'd2));
        send(2'b11, mk(7'h01, 3'd5));
        send(2'b10, mk(7'h20, 3'd4));
        idle(3);
        check_eq("itype_cnt", illegal_cnt, 3);

        // Backpressure: out_ready low for 3 cycles while streaming
        out_ready = 1'b0;
        in_valid  = 1'b1; alu_op = 2'b10; instr = mk(7'h00, 3'd4);
        @(negedge clk);
        check_eq("bp_ready0", in_ready, 1);
        @(posedge clk); #1;
        instr = mk(7'h20, 3'd5);
        @(negedge clk);
        check_eq("bp_ready1", in_ready, 1);
        @(posedge clk); #1;
        instr = mk(7'h00, 3'd3);
        @(negedge clk);
        check_eq("bp_in_ready", in_ready, 0);
        check_eq("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2'b10, instr);
        send(2'b10, mk(7'h00, 3'd6));
        idle(4);

        // Flush with both entries full and a new (illegal) input offered
        out_ready = 1'b0;
        send(2'b10, mk(7'h00, 3'd2));
        send(2'b10, mk(7'h11, 3'd2));
        saved_cnt = exp_cnt;
        in_valid = 1'b1; alu_op = 2'b10; instr = mk(7'h33, 3'd6);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_in_ready", in_ready, 1);
        check_eq("flush_cnt", illegal_cnt, saved_cnt);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(5);
        send(2'b01, mk(7'h00, 3'd0));
        idle(3);
        check_eq("drain_empty", sb.size(), 0);

        // Counter saturation on the 2-bit instance
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        s_alu_op   = 2'b10;
        s_instr    = mk(7'h40, 3'd3);
        s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("sat_cnt", s_illegal_cnt, sat_exp[i]);
        end
        s_in_valid = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
